// File: rtl/rom_rd_arbiter_pkg.sv
// Shared types and constants for the ROM read arbiter.
// The statistics counters are built only when ROM_RD_ARB_STATS_EN is defined.
package rom_arb_pkg;

  // Access sequencing states. The order is accept, issue, capture, respond.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Width of each statistics counter.
  localparam int STAT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/rom_rd_arbiter_if.sv
// Requester-side bus of the ROM read arbiter.
// The requester side uses modport master and the arbiter uses modport slave.
//
// Handshake rules:
//   Request: a transfer happens in a cycle where req_valid[i] & req_ready[i].
//     req_ready is one-hot and is asserted only while the arbiter is idle.
//     A requester holds req_valid and its req_addr slice until it is accepted.
//   Response: rsp_valid is one-hot. rsp_data and rsp_err are stable while it
//     is high. The response completes in the cycle where
//     rsp_valid[i] & rsp_ready[i]. rsp_ready of the other requesters is ignored.
interface rom_rd_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rom_rd_arbiter_rr_pick.sv
// Combinational round-robin selector.
// It returns the first requester at or above ptr, wrapping around, that has
// its request bit set.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from ptr upward and take the first set bit.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter that shares one synchronous-read ROM among N_REQ requesters.
// Only one access is in flight at a time, and each access takes at least 4 cycles.
// Optional statistics (grant_cnt, err_cnt) are enabled with ROM_RD_ARB_STATS_EN.
module rom_rd_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  rom_rd_arbiter_if.slave           bus,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output state_t                    dbg_state
`ifdef ROM_RD_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]   grant_cnt,
  output logic [STAT_W-1:0]         err_cnt
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  id_q;
  logic              in_range_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [ADDR_W-1:0] addr_sel;
  logic              sel_in_range;
  logic              accept;
  logic              rsp_ack;

  rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Select the address slice of the current winner and classify its range.
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) addr_sel = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign sel_in_range = ({1'b0, addr_sel} < DEPTH_V);

  // Acknowledge from the requester that owns the pending response.
  always_comb begin
    rsp_ack = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (id_q == IDX_W'(i)) rsp_ack = bus.rsp_ready[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic and the per-state strobes.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    rom_en        = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    case (state)
      IDLE: begin
        // Gate with rst_n so that no grant is visible while in reset.
        if (rst_n) bus.req_ready = pick_grant;
        if (pick_any) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        rom_en    = in_range_q;
        state_nxt = CAPT;
      end
      CAPT: state_nxt = RESP;
      RESP: begin
        for (int i = 0; i < N_REQ; i++) bus.rsp_valid[i] = (id_q == IDX_W'(i));
        if (rsp_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the request at accept, capture ROM data, clear on response ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      id_q       <= '0;
      in_range_q <= 1'b0;
      rom_addr   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        id_q       <= pick_idx;
        in_range_q <= sel_in_range;
        // An out-of-range access leaves the ROM address unchanged.
        if (sel_in_range) rom_addr <= addr_sel;
        ptr <= (pick_idx == IDX_W'(N_REQ-1)) ? '0 : pick_idx + IDX_W'(1);
      end
      if (state == CAPT) begin
        rsp_data_q <= in_range_q ? rom_data : '0;
        rsp_err_q  <= !in_range_q;
      end
      if (state == RESP && rsp_ack) rsp_err_q <= 1'b0;
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;
  assign dbg_state    = state;

`ifdef ROM_RD_ARB_STATS_EN
  // Saturating per-requester grant counters and the out-of-range counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      err_cnt   <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (pick_idx == IDX_W'(i))
          grant_cnt[i*STAT_W +: STAT_W] <= sat_inc(grant_cnt[i*STAT_W +: STAT_W]);
      end
      if (!sel_in_range) err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule
